// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Lets NUM_CH masters share one synchronous memory. A round-robin arbiter
// picks at most one request per cycle. The winner's command is registered onto
// the mem_* port, and read returns are steered back to the requesting channel
// through a fixed-depth tracking pipeline.
// Optional build macro: MEM_ARB_PRIO_EN gives channel 0 absolute priority.
// Channels 1..NUM_CH-1 then round-robin whenever channel 0 is idle.

module mem_port_arbiter #(
  parameter int NUM_CH      = 4,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int MEM_LATENCY = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        req,
  input  logic [NUM_CH-1:0]        writeEnable,
  input  logic [NUM_CH*ADDR_W-1:0] address,
  input  logic [NUM_CH*DATA_W-1:0] dataToMemory,
  output logic [NUM_CH-1:0]        gnt,
  output logic [NUM_CH-1:0]        rvalid,
  output logic [DATA_W-1:0]        dataFromMemory,
  output logic                     mem_en,
  output logic                     mem_writeEnable,
  output logic [ADDR_W-1:0]        mem_address,
  output logic [DATA_W-1:0]        mem_dataToMemory,
  input  logic [DATA_W-1:0]        mem_dataFromMemory,
  output logic                     busy
);

  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  // One stage per cycle between the grant edge and the cycle in which the
  // memory presents the read data.
  localparam int DEPTH = MEM_LATENCY + 1;

  // Channel index base+k, wrapped modulo NUM_CH (k is 1..NUM_CH).
  function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base, input int k);
    int sum;
    sum = int'(base) + k;
    return PTR_W'((sum >= NUM_CH) ? (sum - NUM_CH) : sum);
  endfunction

  logic [PTR_W-1:0]  last;
  logic [PTR_W-1:0]  rr_id;
  logic              rr_valid;
  logic [PTR_W-1:0]  win_id;
  logic              win_valid;
  logic              prio_hit;
  logic [NUM_CH-1:0] gnt_raw;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic              push;

  logic [DEPTH-1:0]  pipe_valid;
  logic [PTR_W-1:0]  pipe_id [DEPTH];

  // Round-robin search from last+1; the descending loop lets the closest requester win.
  always_comb begin
    rr_id = '0;
    for (int k = NUM_CH; k >= 1; k--) begin
      rr_id = req[wrap_idx(last, k)] ? wrap_idx(last, k) : rr_id;
    end
    rr_valid = |req;
`ifdef MEM_ARB_PRIO_EN
    if (req[0]) begin
      win_valid = 1'b1;
      win_id    = '0;
      prio_hit  = 1'b1;
    end else begin
      win_valid = rr_valid;
      win_id    = rr_id;
      prio_hit  = 1'b0;
    end
`else
    win_valid = rr_valid;
    win_id    = rr_id;
    prio_hit  = 1'b0;
`endif
    gnt_raw = win_valid ? (NUM_CH'(1'b1) << win_id) : '0;
  end

  // Grant is combinational but held low for as long as reset is asserted.
  always_comb begin
    if (reset) begin
      gnt = '0;
    end else begin
      gnt = gnt_raw;
    end
  end

  // Select the winning channel's command fields.
  always_comb begin
    sel_we   = 1'b0;
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      sel_we   = (PTR_W'(i) == win_id) ? writeEnable[i] : sel_we;
      sel_addr = (PTR_W'(i) == win_id) ? address[i*ADDR_W +: ADDR_W] : sel_addr;
      sel_data = (PTR_W'(i) == win_id) ? dataToMemory[i*DATA_W +: DATA_W] : sel_data;
    end
    push = win_valid & ~sel_we;
  end

  // Pointer moves to the winner; a priority grant to channel 0 leaves it alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last <= PTR_W'(NUM_CH - 1);
    end else if (win_valid && !prio_hit) begin
      last <= win_id;
    end
  end

  // Command stage: address and data hold when there is no grant, so the bus stays quiet.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_en           <= 1'b0;
      mem_writeEnable  <= 1'b0;
      mem_address      <= '0;
      mem_dataToMemory <= '0;
    end else begin
      mem_en          <= win_valid;
      mem_writeEnable <= win_valid & sel_we;
      if (win_valid) begin
        mem_address      <= sel_address_fix(sel_addr);
        mem_dataToMemory <= sel_data;
      end
    end
  end

  // Identity helper that keeps the address path width explicit.
  function automatic logic [ADDR_W-1:0] sel_address_fix(input logic [ADDR_W-1:0] a);
    return a;
  endfunction

  // Read tracking: the channel id travels alongside the memory access and
  // steers the captured data back to its channel. busy also covers the
  // return cycle, so it drops the cycle after the last rvalid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe_valid     <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        pipe_id[k] <= '0;
      end
      rvalid         <= '0;
      dataFromMemory <= '0;
      busy           <= 1'b0;
    end else begin
      pipe_valid <= {pipe_valid[DEPTH-2:0], push};
      pipe_id[0] <= win_id;
      for (int k = 1; k < DEPTH; k++) begin
        pipe_id[k] <= pipe_id[k-1];
      end
      rvalid <= pipe_valid[DEPTH-1] ? (NUM_CH'(1'b1) << pipe_id[DEPTH-1]) : '0;
      if (pipe_valid[DEPTH-1]) begin
        dataFromMemory <= mem_dataFromMemory;
      end
      busy <= push | (|pipe_valid);
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter (NUM_CH=4, MEM_LATENCY=1).
// A cycle monitor models arbitration, the command stage and read returns
// (a scoreboard queue of expected returns). A vector table and a few hand
// sequences cover the reset, hazard, routing and reset-in-flight cases.

module tb_mem_port_arbiter;

  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int L  = 1;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req;
  logic [N-1:0]    writeEnable;
  logic [N*AW-1:0] address;
  logic [N*DW-1:0] dataToMemory;
  logic [N-1:0]    gnt;
  logic [N-1:0]    rvalid;
  logic [DW-1:0]   dataFromMemory;
  logic            mem_en;
  logic            mem_writeEnable;
  logic [AW-1:0]   mem_address;
  logic [DW-1:0]   mem_dataToMemory;
  logic [DW-1:0]   mem_dataFromMemory;
  logic            busy;

  mem_port_arbiter #(.NUM_CH(N), .ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(L)) dut (
    .clk(clk), .reset(reset), .req(req), .writeEnable(writeEnable),
    .address(address), .dataToMemory(dataToMemory), .gnt(gnt), .rvalid(rvalid),
    .dataFromMemory(dataFromMemory), .mem_en(mem_en), .mem_writeEnable(mem_writeEnable),
    .mem_address(mem_address), .mem_dataToMemory(mem_dataToMemory),
    .mem_dataFromMemory(mem_dataFromMemory), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous memory with L cycles from command to data.
  logic [DW-1:0] tb_mem [0:65535];
  logic [DW-1:0] rd_q [L];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_writeEnable) tb_mem[mem_address] <= mem_dataToMemory;
      else rd_q[0] <= tb_mem[mem_address];
    end
    for (int k = 1; k < L; k++) rd_q[k] <= rd_q[k-1];
  end
  assign mem_dataFromMemory = rd_q[L-1];

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model state.
  typedef struct { int due; int ch; logic [DW-1:0] data; } rd_t;
  rd_t           sb[$];
  logic [DW-1:0] ref_mem [0:65535];
  int            m_last = N - 1;
  logic          m_prev_g = 1'b0;
  logic          m_prev_we = 1'b0;
  logic [AW-1:0] m_prev_a = '0;
  logic [DW-1:0] m_prev_d = '0;
  int            mon_wid;
  int            mon_idx;
  logic [N-1:0]  mon_eg;
  logic [N-1:0]  mon_erv;
  logic          mon_ebusy;

  // Per-cycle monitor: compare every output against the model, then advance it.
  always @(negedge clk) begin
    if (reset) begin
      chk("rst_gnt", gnt, 0);
      chk("rst_mem_en", mem_en, 0);
      chk("rst_rvalid", rvalid, 0);
      chk("rst_busy", busy, 0);
      sb.delete();
      m_last   = N - 1;
      m_prev_g = 1'b0;
    end else begin
      mon_ebusy = (sb.size() != 0);
      mon_erv   = '0;
      if (sb.size() != 0 && sb[0].due == cyc) begin
        mon_erv = 4'b0001 << sb[0].ch;
        chk("mon_rdata", dataFromMemory, sb[0].data);
        void'(sb.pop_front());
      end
      chk("mon_rvalid", rvalid, mon_erv);
      chk("mon_busy", busy, mon_ebusy);
      chk("mon_mem_en", mem_en, m_prev_g);
      chk("mon_mem_we", mem_writeEnable, m_prev_g & m_prev_we);
      if (m_prev_g) begin
        chk("mon_mem_addr", mem_address, m_prev_a);
        chk("mon_mem_data", mem_dataToMemory, m_prev_d);
      end
      mon_wid = -1;
      for (int k = 1; k <= N; k++) begin
        mon_idx = (m_last + k) % N;
        if (mon_wid < 0 && req[mon_idx]) mon_wid = mon_idx;
      end
`ifdef MEM_ARB_PRIO_EN
      if (req[0]) mon_wid = 0;
`endif
      mon_eg = (mon_wid >= 0) ? (4'b0001 << mon_wid) : 4'b0000;
      chk("mon_gnt", gnt, mon_eg);
      m_prev_g = (mon_wid >= 0);
      if (mon_wid >= 0) begin
        m_prev_we = writeEnable[mon_wid];
        m_prev_a  = address[mon_wid*AW +: AW];
        m_prev_d  = dataToMemory[mon_wid*DW +: DW];
        if (m_prev_we) ref_mem[m_prev_a] = m_prev_d;
        else sb.push_back('{due: cyc + L + 2, ch: mon_wid, data: ref_mem[m_prev_a]});
`ifdef MEM_ARB_PRIO_EN
        if (mon_wid != 0) m_last = mon_wid;
`else
        m_last = mon_wid;
`endif
      end
    end
  end

  // Single-channel request held until accepted; returns the grant cycle.
  task automatic issue(input int ch, input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, output int gc);
    logic got;
    got = 1'b0;
    gc  = -1;
    req = '0;
    req[ch] = 1'b1;
    writeEnable[ch] = we;
    address[ch*AW +: AW] = a;
    dataToMemory[ch*DW +: DW] = d;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (gnt[ch]) begin
        got = 1'b1;
        gc  = cyc;
        break;
      end
      @(posedge clk);
      #1;
    end
    chk("issue_granted", got, 1);
    @(posedge clk);
    #1;
    req = '0;
  endtask

  typedef struct { logic [N-1:0] req; logic [N-1:0] exp_gnt; logic exp_mem_en; } vec_t;
  vec_t vecs[$];

  int g, g1, g3, g0;
  logic [N-1:0] seen;

  initial begin
`ifdef MEM_ARB_PRIO_EN
    for (int i = 0; i < 4; i++) vecs.push_back('{4'b0111, 4'b0001, (i != 0)});
    vecs.push_back('{4'b0110, 4'b0010, 1'b1});
    vecs.push_back('{4'b0110, 4'b0100, 1'b1});
    vecs.push_back('{4'b0110, 4'b0010, 1'b1});
    vecs.push_back('{4'b0110, 4'b0100, 1'b1});
    vecs.push_back('{4'b1110, 4'b1000, 1'b1});
    vecs.push_back('{4'b0000, 4'b0000, 1'b1});
`else
    for (int i = 0; i < 8; i++) vecs.push_back('{4'b1111, 4'b0001 << (i % 4), (i != 0)});
    vecs.push_back('{4'b0110, 4'b0010, 1'b1});
    vecs.push_back('{4'b0110, 4'b0100, 1'b1});
    vecs.push_back('{4'b1001, 4'b1000, 1'b1});
    vecs.push_back('{4'b1001, 4'b0001, 1'b1});
    vecs.push_back('{4'b0000, 4'b0000, 1'b1});
    vecs.push_back('{4'b1000, 4'b1000, 1'b0});
    vecs.push_back('{4'b0000, 4'b0000, 1'b1});
`endif
    reset = 1'b1;
    req = '0;
    writeEnable = '0;
    address = '0;
    dataToMemory = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_addr", mem_address, 0);
    chk("rst_rdata", dataFromMemory, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    // Grant ch0 once so the pointer moves before the mid-cycle reset.
    issue(0, 1'b1, 16'h0200, 16'h5555, g);
    chk("pre_rst_mem_en", mem_en, 1);
    reset = 1'b1;
    req = 4'b1111;
    writeEnable = 4'b1111;
    for (int i = 0; i < N; i++) begin
      address[i*AW +: AW] = 16'h0100 + 16'(i);
      dataToMemory[i*DW +: DW] = 16'hA000 + 16'(i);
    end
    #1;
    chk("rst_now_gnt", gnt, 0);
    chk("rst_now_mem_en", mem_en, 0);
    chk("rst_now_rvalid", rvalid, 0);
    @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      req = vecs[i].req;
      @(negedge clk);
      chk($sformatf("vec%0d_gnt", i), gnt, vecs[i].exp_gnt);
      chk($sformatf("vec%0d_mem_en", i), mem_en, vecs[i].exp_mem_en);
    end
    @(posedge clk);
    #1;

    // Write then read of the same address on consecutive grants.
    issue(2, 1'b1, 16'h0010, 16'hBEEF, g);
    issue(1, 1'b0, 16'h0010, 16'h0000, g1);
    chk("wr_rd_b2b", g1 - g, 1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (rvalid != 0) break;
    end
    chk("wr_rd_latency", cyc - g1, 3);
    chk("wr_rd_rvalid", rvalid, 4'b0010);
    chk("wr_rd_data", dataFromMemory, 16'hBEEF);
    @(posedge clk);
    #1;

    // Back-to-back reads from different channels are routed in grant order.
    issue(3, 1'b1, 16'h0004, 16'h1111, g);
    issue(0, 1'b1, 16'h0008, 16'h2222, g);
    issue(3, 1'b0, 16'h0004, 16'h0000, g3);
    issue(0, 1'b0, 16'h0008, 16'h0000, g0);
    chk("rt_b2b", g0 - g3, 1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (rvalid != 0) break;
    end
    chk("rt_latency", cyc - g3, 3);
    chk("rt_rvalid3", rvalid, 4'b1000);
    chk("rt_data3", dataFromMemory, 16'h1111);
    chk("rt_busy_ret", busy, 1);
    @(negedge clk);
    chk("rt_rvalid0", rvalid, 4'b0001);
    chk("rt_data0", dataFromMemory, 16'h2222);
    @(negedge clk);
    chk("rt_busy_after", busy, 0);
    chk("rt_rvalid_after", rvalid, 0);
    @(posedge clk);
    #1;

    // Reset one cycle after a read grant discards it.
    issue(0, 1'b0, 16'h0008, 16'h0000, g);
    chk("rif_busy_before", busy, 1);
    reset = 1'b1;
    #1;
    chk("rif_rvalid_now", rvalid, 0);
    chk("rif_busy_now", busy, 0);
    @(posedge clk);
    #2 reset = 1'b0;
    seen = '0;
    repeat (8) begin
      @(negedge clk);
      seen = seen | rvalid;
    end
    chk("rif_no_rvalid", seen, 0);
    chk("rif_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run still active at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
